// File: rtl/barrel_rotator_pipe_if.sv
// ---------------------------------------------------------------------------
// barrel_rotator_pipe_if
//
// Bundles the operand-side (Load/ready) and result-side (valid/out_ready)
// handshakes of barrel_rotator_pipe.
//
// Parameters:
//   WIDTH  data width (power of two, 4..64)
//   SHW    shift-amount width, $clog2(WIDTH)
//
// Signals:
//   Load       operation valid from the source
//   ready      unit can take an operation this cycle
//   mode       00 ROL, 01 ROR, 10 SHL, 11 SAR
//   sel        shift/rotate amount
//   data_in    operand
//   data_out   result
//   zero       data_out == 0, qualified by valid
//   valid      data_out/zero hold a result
//   out_ready  consumer takes the result this cycle
//
// Modports:
//   master  the environment: drives the operation and out_ready
//   slave   the rotator: drives ready and the result
// ---------------------------------------------------------------------------
interface barrel_rotator_pipe_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             Load;
  logic             ready;
  logic [1:0]       mode;
  logic [SHW-1:0]   sel;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             zero;
  logic             valid;
  logic             out_ready;

  modport master (
    output Load, mode, sel, data_in, out_ready,
    input  ready, data_out, zero, valid
  );

  modport slave (
    input  Load, mode, sel, data_in, out_ready,
    output ready, data_out, zero, valid
  );
endinterface

// File: rtl/barrel_rotator_pipe.sv
// ---------------------------------------------------------------------------
// barrel_rotator_pipe
//
// WIDTH-bit barrel unit: rotate left/right, logical shift left, arithmetic
// shift right. The datapath is SHW cascaded mux stages; stage k applies
// 2^k positions of the requested operation when sel[k] is set.
//
// Build option (macro BARREL_ROTATOR_PIPE_EN):
//   defined    every mux stage is registered, latency SHW
//   undefined  all mux stages combinational + one output register, latency 1
// Handshake, results and reset behaviour are the same in both builds.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    barrel_rotator_pipe_if.slave (Load/ready operand handshake,
//          valid/out_ready result handshake, mode/sel/data_in,
//          data_out/zero)
//
// Flow control: one global advance enable (en = !valid || out_ready) moves
// every stage and its valid bit together, so bubbles travel through the
// pipe uncompressed and a stall freezes everything.
// ---------------------------------------------------------------------------
module barrel_rotator_pipe #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  barrel_rotator_pipe_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] MODE_ROL = 2'b00;
  localparam logic [1:0] MODE_ROR = 2'b01;
  localparam logic [1:0] MODE_SHL = 2'b10;

  // One mux stage: apply 2^k positions of the operation if s[k] is set.
  // sgn is the sign bit of the original operand, carried down the pipe so
  // the SAR fill never depends on intermediate results.
  function automatic logic [WIDTH-1:0] stage_mux(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       m,
    input logic [SHW-1:0]   s,
    input logic             sgn,
    input int               k
  );
    int unsigned      amt;
    logic [WIDTH-1:0] fill;
    amt  = 1 << k;
    fill = sgn ? ~({WIDTH{1'b1}} >> amt) : '0;
    stage_mux = d;
    if (s[k]) begin
      case (m)
        MODE_ROL: stage_mux = (d << amt) | (d >> (WIDTH - amt));
        MODE_ROR: stage_mux = (d >> amt) | (d << (WIDTH - amt));
        MODE_SHL: stage_mux = d << amt;
        default:  stage_mux = (d >> amt) | fill;
      endcase
    end
  endfunction

  logic             en;
  logic             accept;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  assign en        = !out_valid || bus.out_ready;
  assign bus.ready = en && reset;
  assign accept    = bus.Load && bus.ready;

  assign bus.valid    = out_valid;
  assign bus.data_out = out_data;
  assign bus.zero     = out_zero;

`ifdef BARREL_ROTATOR_PIPE_EN

  // Stage k register holds the result of mux stage k. Control (mode, sel,
  // sign) is only needed by the stages that follow, so the last stage
  // carries data/valid/zero only.
  logic [SHW-1:0][WIDTH-1:0] stg_data_reg;
  logic [SHW-1:0]            stg_valid_reg;
  logic [SHW-2:0][1:0]       stg_mode_reg;
  logic [SHW-2:0][SHW-1:0]   stg_sel_reg;
  logic [SHW-2:0]            stg_sign_reg;
  logic                      zero_reg;
  logic [WIDTH-1:0]          last_result;

  // Final mux stage, also the source of the zero flag so it is registered
  // in the same edge as the data it describes.
  assign last_result = stage_mux(stg_data_reg[SHW-2], stg_mode_reg[SHW-2],
                                 stg_sel_reg[SHW-2], stg_sign_reg[SHW-2],
                                 SHW - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg_data_reg  <= '0;
      stg_valid_reg <= '0;
      stg_mode_reg  <= '0;
      stg_sel_reg   <= '0;
      stg_sign_reg  <= '0;
      zero_reg      <= 1'b0;
    end else if (en) begin
      stg_data_reg[0]  <= stage_mux(bus.data_in, bus.mode, bus.sel,
                                    bus.data_in[WIDTH-1], 0);
      stg_valid_reg[0] <= accept;
      stg_mode_reg[0]  <= bus.mode;
      stg_sel_reg[0]   <= bus.sel;
      stg_sign_reg[0]  <= bus.data_in[WIDTH-1];
      for (int k = 1; k < SHW - 1; k++) begin
        stg_data_reg[k]  <= stage_mux(stg_data_reg[k-1], stg_mode_reg[k-1],
                                      stg_sel_reg[k-1], stg_sign_reg[k-1], k);
        stg_valid_reg[k] <= stg_valid_reg[k-1];
        stg_mode_reg[k]  <= stg_mode_reg[k-1];
        stg_sel_reg[k]   <= stg_sel_reg[k-1];
        stg_sign_reg[k]  <= stg_sign_reg[k-1];
      end
      stg_data_reg[SHW-1]  <= last_result;
      stg_valid_reg[SHW-1] <= stg_valid_reg[SHW-2];
      zero_reg             <= (last_result == '0);
    end
  end

  assign out_valid = stg_valid_reg[SHW-1];
  assign out_data  = stg_data_reg[SHW-1];
  assign out_zero  = zero_reg;

`else

  logic [WIDTH-1:0] comb_result;
  logic [WIDTH-1:0] data_reg;
  logic             zero_reg;
  logic             valid_reg;

  // All SHW mux stages in one combinational cascade.
  always_comb begin
    comb_result = bus.data_in;
    for (int k = 0; k < SHW; k++) begin
      comb_result = stage_mux(comb_result, bus.mode, bus.sel,
                              bus.data_in[WIDTH-1], k);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_reg  <= '0;
      zero_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else if (en) begin
      data_reg  <= comb_result;
      zero_reg  <= (comb_result == '0);
      valid_reg <= accept;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_zero  = zero_reg;

`endif

endmodule

// File: tb/tb_barrel_rotator_pipe.sv
// ---------------------------------------------------------------------------
// tb_barrel_rotator_pipe
//
// Scoreboard bench for barrel_rotator_pipe at WIDTH=8. The driver pushes the
// expected result of every accepted operation into a queue; an independent
// monitor pops and compares whenever a result is taken. Works for both the
// single-stage and the pipelined build (BARREL_ROTATOR_PIPE_EN).
// ---------------------------------------------------------------------------
module tb_barrel_rotator_pipe;

`ifdef BARREL_ROTATOR_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic [7:0]  d;
    logic        z;
    logic [31:0] acc;
    logic        chk;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_fail;
  logic lat_chk;
  exp_t exp_q[$];
  int   out_log[$];

  barrel_rotator_pipe_if #(.WIDTH(8)) bus ();

  barrel_rotator_pipe #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Bit-by-bit reference: each result bit picks its source bit directly.
  function automatic logic [7:0] ref_op(input logic [1:0] m, input int s,
                                        input logic [7:0] d);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      case (m)
        2'd0: r[(i + s) % 8] = d[i];
        2'd1: r[i] = d[(i + s) % 8];
        2'd2: if (i >= s) r[i] = d[i - s];
        default: r[i] = (i + s < 8) ? d[i + s] : d[7];
      endcase
    end
    return r;
  endfunction

  // Present one operation, hold it until accepted, push its expectation.
  task automatic issue(input logic [1:0] m, input logic [2:0] s,
                       input logic [7:0] d, input logic [7:0] e,
                       input logic ez, output int waits);
    exp_t it;
    logic acc;
    acc   = 1'b0;
    waits = 0;
    bus.Load    = 1'b1;
    bus.mode    = m;
    bus.sel     = s;
    bus.data_in = d;
    while (!acc && waits < 50) begin
      @(negedge clk);
      if (bus.ready) begin
        acc = 1'b1;
        it  = '{d: e, z: ez, acc: cyc, chk: lat_chk};
        exp_q.push_back(it);
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    bus.Load = 1'b0;
    check("accepted", {31'd0, acc}, 32'd1);
  endtask

  task automatic issue_model(input logic [1:0] m, input logic [2:0] s,
                             input logic [7:0] d, output int waits);
    logic [7:0] e;
    e = ref_op(m, int'(s), d);
    issue(m, s, d, e, (e == 8'h00), waits);
  endtask

  task automatic idle(input int n);
    bus.Load = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 32'd0);
  endtask

  // Monitor: compares every taken result against the queue head, checks the
  // ready equation and that a stalled result holds still.
  logic       stalled_prev;
  logic [7:0] held_data;
  logic       held_zero;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      stalled_prev = 1'b0;
    end else begin
      check("ready", {31'd0, bus.ready}, {31'd0, (!bus.valid || bus.out_ready)});
      if (stalled_prev) begin
        check("hold_valid", {31'd0, bus.valid}, 32'd1);
        check("hold_data", {24'd0, bus.data_out}, {24'd0, held_data});
        check("hold_zero", {31'd0, bus.zero}, {31'd0, held_zero});
      end
      if (bus.valid && bus.out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out: got 0x%0h with no operation outstanding (cycle %0d)",
                   bus.data_out, cyc);
        end else begin
          e = exp_q.pop_front();
          check("data_out", {24'd0, bus.data_out}, {24'd0, e.d});
          check("zero", {31'd0, bus.zero}, {31'd0, e.z});
          if (e.chk) check("latency", 32'(cyc - int'(e.acc)), 32'(LAT));
          out_log.push_back(cyc);
        end
      end
      stalled_prev = bus.valid && !bus.out_ready;
      held_data    = bus.data_out;
      held_zero    = bus.zero;
    end
  end

  // {mode, sel, data_in, expected, expected zero}
  logic [21:0] vec [15];

  initial begin
    int w;
    cyc          = 0;
    n_checks     = 0;
    n_fail       = 0;
    lat_chk      = 1'b1;
    stalled_prev = 1'b0;
    held_data    = '0;
    held_zero    = 1'b0;
    bus.Load      = 1'b0;
    bus.mode      = 2'd0;
    bus.sel       = 3'd0;
    bus.data_in   = 8'h00;
    bus.out_ready = 1'b1;
    vec = '{
      {2'd0, 3'd1, 8'h81, 8'h03, 1'b0},
      {2'd1, 3'd1, 8'h81, 8'hC0, 1'b0},
      {2'd2, 3'd3, 8'h81, 8'h08, 1'b0},
      {2'd3, 3'd2, 8'h90, 8'hE4, 1'b0},
      {2'd3, 3'd2, 8'h70, 8'h1C, 1'b0},
      {2'd0, 3'd0, 8'hA5, 8'hA5, 1'b0},
      {2'd1, 3'd0, 8'h3C, 8'h3C, 1'b0},
      {2'd2, 3'd0, 8'h5A, 8'h5A, 1'b0},
      {2'd3, 3'd0, 8'hF0, 8'hF0, 1'b0},
      {2'd2, 3'd1, 8'h80, 8'h00, 1'b1},
      {2'd0, 3'd1, 8'h80, 8'h01, 1'b0},
      {2'd1, 3'd7, 8'h01, 8'h02, 1'b0},
      {2'd3, 3'd7, 8'h80, 8'hFF, 1'b0},
      {2'd2, 3'd7, 8'h01, 8'h80, 1'b0},
      {2'd0, 3'd4, 8'h12, 8'h21, 1'b0}
    };

    // Reset state (make a real falling edge on reset).
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("rst_valid", {31'd0, bus.valid}, 32'd0);
    check("rst_ready", {31'd0, bus.ready}, 32'd0);
    check("rst_data", {24'd0, bus.data_out}, 32'd0);
    check("rst_zero", {31'd0, bus.zero}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Directed mode and zero-flag vectors, back to back.
    for (int i = 0; i < 15; i++) begin
      logic [21:0] v;
      v = vec[i];
      issue(v[21:20], v[19:17], v[16:9], v[8:1], v[0], w);
    end
    idle(1);
    drain();

    // Streaming: 24 consecutive operations, ready must never drop.
    out_log.delete();
    for (int i = 0; i < 24; i++) begin
      issue_model(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)), w);
      check("stream_ready", w, 32'd0);
    end
    idle(1);
    drain();
    check("stream_count", out_log.size(), 32'd24);
    for (int i = 1; i < out_log.size(); i++)
      check("stream_back_to_back", 32'(out_log[i] - out_log[i-1]), 32'd1);

    // Backpressure: consumer stalls for 5 cycles while the source streams.
    lat_chk = 1'b0;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          int wb;
          issue_model(2'($urandom_range(0, 3)), 3'($urandom_range(1, 7)),
                      8'($urandom_range(1, 255)), wb);
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    idle(1);
    drain();
    lat_chk = 1'b1;

    // Bubbles: Load pattern 1,0,1,0,0,1.
    out_log.delete();
    issue_model(2'd0, 3'd2, 8'h11, w);
    idle(1);
    issue_model(2'd1, 3'd3, 8'h0F, w);
    idle(2);
    issue_model(2'd3, 3'd1, 8'hC2, w);
    idle(1);
    drain();
    check("bubble_count", out_log.size(), 32'd3);
    if (out_log.size() == 3) begin
      check("bubble_gap0", 32'(out_log[1] - out_log[0]), 32'd2);
      check("bubble_gap1", 32'(out_log[2] - out_log[1]), 32'd3);
    end

    // Reset with results in flight.
    bus.out_ready = 1'b0;
    for (int i = 0; i < LAT; i++) issue_model(2'd0, 3'd0, 8'h81, w);
    check("inflight_valid", {31'd0, bus.valid}, 32'd1);
    reset = 1'b0;
    #2;
    check("async_valid", {31'd0, bus.valid}, 32'd0);
    check("async_data", {24'd0, bus.data_out}, 32'd0);
    check("async_zero", {31'd0, bus.zero}, 32'd0);
    check("async_ready", {31'd0, bus.ready}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    #1 reset = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_reset_valid", {31'd0, bus.valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    issue_model(2'd2, 3'd2, 8'h3F, w);
    idle(1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
